// File: rtl/exc_pkg.sv
// Shared exception-tracking definitions: MIPS ExcCode constants and the
// default-width record layout.
package exc_pkg;

    localparam int unsigned EXC_CODE_W = 5;
    localparam int unsigned EXC_PC_W   = 32;

    localparam logic [EXC_CODE_W-1:0] EXC_INT  = EXC_CODE_W'(0);
    localparam logic [EXC_CODE_W-1:0] EXC_ADEL = EXC_CODE_W'(4);
    localparam logic [EXC_CODE_W-1:0] EXC_ADES = EXC_CODE_W'(5);
    localparam logic [EXC_CODE_W-1:0] EXC_RI   = EXC_CODE_W'(10);
    localparam logic [EXC_CODE_W-1:0] EXC_OV   = EXC_CODE_W'(12);

    typedef struct packed {
        logic                  v;
        logic                  exc;
        logic [EXC_CODE_W-1:0] code;
        logic [EXC_PC_W-1:0]   pc;
        logic                  bd;
    } exc_rec_t;

    localparam int unsigned EXC_REC_W = $bits(exc_rec_t);

endpackage

// File: rtl/pipeline_exc_chain_if.sv
// Fetch-side entry, per-stage injection and commit-side record of the
// exception chain.
interface pipeline_exc_chain_if
    import exc_pkg::*;
#(
    parameter int unsigned STAGES = 3,
    parameter int unsigned CODE_W = EXC_CODE_W,
    parameter int unsigned PC_W   = EXC_PC_W
);
    logic                     in_valid;
    logic [PC_W-1:0]          in_pc;
    logic                     in_bd;
    logic [STAGES-1:0]        inj_valid;
    logic [STAGES*CODE_W-1:0] inj_code;

    logic                     out_valid;
    logic                     out_exc;
    logic [CODE_W-1:0]        out_code;
    logic [PC_W-1:0]          out_pc;
    logic                     out_bd;

    modport slave (
        input  in_valid, in_pc, in_bd, inj_valid, inj_code,
        output out_valid, out_exc, out_code, out_pc, out_bd
    );

    modport master (
        output in_valid, in_pc, in_bd, inj_valid, inj_code,
        input  out_valid, out_exc, out_code, out_pc, out_bd
    );
endinterface

// File: rtl/pipeline_exc_stage.sv
// One exception-record register: merges a stage-local injection into the
// incoming record and applies reset/flush/stall/bubble priority.
module pipeline_exc_stage
    import exc_pkg::*;
#(
    parameter int unsigned CODE_W = EXC_CODE_W,
    parameter int unsigned PC_W   = EXC_PC_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_exc_flush,
    input  logic              i_flush,
    input  logic              i_en,
    input  logic              i_en_prev,
    input  logic              i_src_v,
    input  logic              i_src_exc,
    input  logic [CODE_W-1:0] i_src_code,
    input  logic [PC_W-1:0]   i_src_pc,
    input  logic              i_src_bd,
    input  logic              i_inj_valid,
    input  logic [CODE_W-1:0] i_inj_code,
    output logic              o_v,
    output logic              o_exc,
    output logic [CODE_W-1:0] o_code,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_bd
);

    logic              r_v;
    logic              r_exc;
    logic [CODE_W-1:0] r_code;
    logic [PC_W-1:0]   r_pc;
    logic              r_bd;

    logic              w_exc;
    logic [CODE_W-1:0] w_code;

    // An earlier exception already on the record always wins over this stage's.
    always_comb begin
        w_exc  = i_src_exc;
        w_code = i_src_code;
        if (i_src_v && !i_src_exc && i_inj_valid) begin
            w_exc  = 1'b1;
            w_code = i_inj_code;
        end
    end

    // Bubble when the predecessor is stalled so its held record isn't duplicated.
    always_ff @(posedge clk) begin
        if (reset || i_exc_flush || i_flush || (i_en && !i_en_prev)) begin
            r_v    <= 1'b0;
            r_exc  <= 1'b0;
            r_code <= '0;
            r_pc   <= '0;
            r_bd   <= 1'b0;
        end else if (i_en) begin
            r_v    <= i_src_v;
            r_exc  <= w_exc;
            r_code <= w_code;
            r_pc   <= i_src_pc;
            r_bd   <= i_src_bd;
        end
    end

    assign o_v    = r_v;
    assign o_exc  = r_exc;
    assign o_code = r_code;
    assign o_pc   = r_pc;
    assign o_bd   = r_bd;

endmodule

// File: rtl/pipeline_exc_chain.sv
// Exception-record pipeline from fetch to commit; the last stage's record
// feeds CP0.
module pipeline_exc_chain
    import exc_pkg::*;
#(
    parameter int unsigned STAGES = 3,
    parameter int unsigned CODE_W = EXC_CODE_W,
    parameter int unsigned PC_W   = EXC_PC_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [STAGES-1:0] en,
    input  logic [STAGES-1:0] flush,
    input  logic              exc_flush,
    pipeline_exc_chain_if.slave bus
);

    logic              w_v    [STAGES];
    logic              w_exc  [STAGES];
    logic [CODE_W-1:0] w_code [STAGES];
    logic [PC_W-1:0]   w_pc   [STAGES];
    logic              w_bd   [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic              w_src_v;
        logic              w_src_exc;
        logic [CODE_W-1:0] w_src_code;
        logic [PC_W-1:0]   w_src_pc;
        logic              w_src_bd;
        logic              w_en_prev;

        if (i == 0) begin : g_fetch
            // Fetch never carries an exception; stage 0 has no predecessor to stall.
            assign w_src_v    = bus.in_valid;
            assign w_src_exc  = 1'b0;
            assign w_src_code = '0;
            assign w_src_pc   = bus.in_pc;
            assign w_src_bd   = bus.in_bd;
            assign w_en_prev  = 1'b1;
        end else begin : g_chain
            assign w_src_v    = w_v[i-1];
            assign w_src_exc  = w_exc[i-1];
            assign w_src_code = w_code[i-1];
            assign w_src_pc   = w_pc[i-1];
            assign w_src_bd   = w_bd[i-1];
            assign w_en_prev  = en[i-1];
        end

        pipeline_exc_stage #(
            .CODE_W (CODE_W),
            .PC_W   (PC_W)
        ) u_stage (
            .clk         (clk),
            .reset       (reset),
            .i_exc_flush (exc_flush),
            .i_flush     (flush[i]),
            .i_en        (en[i]),
            .i_en_prev   (w_en_prev),
            .i_src_v     (w_src_v),
            .i_src_exc   (w_src_exc),
            .i_src_code  (w_src_code),
            .i_src_pc    (w_src_pc),
            .i_src_bd    (w_src_bd),
            .i_inj_valid (bus.inj_valid[i]),
            .i_inj_code  (bus.inj_code[i*CODE_W +: CODE_W]),
            .o_v         (w_v[i]),
            .o_exc       (w_exc[i]),
            .o_code      (w_code[i]),
            .o_pc        (w_pc[i]),
            .o_bd        (w_bd[i])
        );
    end

    assign bus.out_valid = w_v[STAGES-1];
    assign bus.out_exc   = w_exc[STAGES-1];
    assign bus.out_code  = w_code[STAGES-1];
    assign bus.out_pc    = w_pc[STAGES-1];
    assign bus.out_bd    = w_bd[STAGES-1];

endmodule

// File: tb/tb_pipeline_exc_chain.sv
// Directed-vector bench for pipeline_exc_chain with STAGES=3.
module tb_pipeline_exc_chain;
    import exc_pkg::*;

    localparam int unsigned STAGES = 3;
    localparam int unsigned CODE_W = EXC_CODE_W;
    localparam int unsigned PC_W   = EXC_PC_W;
    localparam int unsigned REC_W  = 2 + CODE_W + PC_W + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] flush;
    logic              exc_flush;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_exc_chain_if #(.STAGES(STAGES), .CODE_W(CODE_W), .PC_W(PC_W)) bus ();

    pipeline_exc_chain #(.STAGES(STAGES), .CODE_W(CODE_W), .PC_W(PC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .exc_flush (exc_flush),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [REC_W-1:0] rec(input logic v, input logic e,
                                             input logic [CODE_W-1:0] c,
                                             input logic [PC_W-1:0] pc, input logic bd);
        return {v, e, c, pc, bd};
    endfunction

    function automatic logic [REC_W-1:0] observed();
        return {bus.out_valid, bus.out_exc, bus.out_code, bus.out_pc, bus.out_bd};
    endfunction

    task automatic check(input string tag, input logic [REC_W-1:0] got,
                         input logic [REC_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [PC_W-1:0] pc, input logic bd);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_bd    = bd;
    endtask

    task automatic drive_inj(input logic [STAGES-1:0] vld, input logic [CODE_W-1:0] c0,
                             input logic [CODE_W-1:0] c1, input logic [CODE_W-1:0] c2);
        bus.inj_valid = vld;
        bus.inj_code  = {c2, c1, c0};
    endtask

    localparam logic [REC_W-1:0] ZERO = '0;

    initial begin
        reset     = 1'b1;
        en        = '1;
        flush     = '0;
        exc_flush = 1'b0;
        drive_in(1'b0, '0, 1'b0);
        drive_inj('0, '0, '0, '0);

        // Reset state and first post-reset cycle
        step();
        step();
        check("reset", observed(), ZERO);
        reset = 1'b0;
        step();
        check("post_reset_bubble", observed(), ZERO);

        // Straight flow: 3-cycle latency
        drive_in(1'b1, 32'h0000_3000, 1'b0);
        step();
        drive_in(1'b0, '0, 1'b0);
        check("flow_e1", observed(), ZERO);
        step();
        check("flow_e2", observed(), ZERO);
        step();
        check("flow_out", observed(), rec(1'b1, 1'b0, EXC_INT, 32'h0000_3000, 1'b0));
        step();
        check("flow_drain", observed(), ZERO);

        // Earliest wins: AdEL at stage 0, Ov at stage 2 two cycles later
        drive_in(1'b1, 32'h0000_3004, 1'b1);
        drive_inj(3'b001, EXC_ADEL, '0, '0);
        step();
        drive_in(1'b0, '0, 1'b0);
        drive_inj('0, '0, '0, '0);
        step();
        drive_inj(3'b100, '0, '0, EXC_OV);
        step();
        drive_inj('0, '0, '0, '0);
        check("earliest_wins", observed(), rec(1'b1, 1'b1, EXC_ADEL, 32'h0000_3004, 1'b1));

        // Late injection on a clean instruction, and on a bubble behind it
        drive_in(1'b1, 32'h0000_3040, 1'b0);
        step();
        drive_in(1'b0, '0, 1'b0);
        step();
        drive_inj(3'b100, '0, '0, EXC_OV);
        step();
        check("inj_stage2", observed(), rec(1'b1, 1'b1, EXC_OV, 32'h0000_3040, 1'b0));
        step();
        drive_inj('0, '0, '0, '0);
        check("inj_on_bubble", observed(), ZERO);

        // Code 0 (Int) injected at stage 1 is a real exception
        drive_in(1'b1, 32'h0000_3008, 1'b0);
        step();
        drive_in(1'b0, '0, 1'b0);
        drive_inj(3'b010, '0, EXC_INT, '0);
        step();
        drive_inj('0, '0, '0, '0);
        step();
        check("code0_exc", observed(), rec(1'b1, 1'b1, EXC_INT, 32'h0000_3008, 1'b0));

        // Stall stage 0 for two cycles
        drive_in(1'b1, 32'h0000_300C, 1'b1);
        step();
        drive_in(1'b0, '0, 1'b0);
        en = 3'b110;
        step();
        check("stall_bub1", observed(), ZERO);
        step();
        check("stall_bub2", observed(), ZERO);
        en = 3'b111;
        step();
        check("stall_resume", observed(), ZERO);
        step();
        check("stall_arrive", observed(), rec(1'b1, 1'b0, EXC_INT, 32'h0000_300C, 1'b1));
        step();
        check("stall_no_dup", observed(), ZERO);

        // Flush of stage 1 wins over its stall
        drive_in(1'b1, 32'h0000_3004, 1'b0);
        drive_inj(3'b001, EXC_RI, '0, '0);
        step();
        drive_in(1'b0, '0, 1'b0);
        drive_inj('0, '0, '0, '0);
        step();
        en    = 3'b101;
        flush = 3'b010;
        step();
        en    = 3'b111;
        flush = 3'b000;
        check("flush_stall_e3", observed(), ZERO);
        step();
        check("flush_stall_e4", observed(), ZERO);
        step();
        check("flush_stall_e5", observed(), ZERO);

        // exc_flush with injections everywhere
        for (int k = 0; k < 3; k++) begin
            drive_in(1'b1, PC_W'(32'h0000_3010 + 4 * k), 1'b0);
            step();
        end
        check("fill_out", observed(), rec(1'b1, 1'b0, EXC_INT, 32'h0000_3010, 1'b0));
        exc_flush = 1'b1;
        drive_in(1'b1, 32'h0000_301C, 1'b0);
        drive_inj(3'b111, EXC_ADEL, EXC_RI, EXC_OV);
        step();
        exc_flush = 1'b0;
        drive_in(1'b0, '0, 1'b0);
        drive_inj('0, '0, '0, '0);
        check("exc_flush_out", observed(), ZERO);
        step();
        check("exc_flush_e2", observed(), ZERO);
        step();
        check("exc_flush_e3", observed(), ZERO);

        // Reset while all stages hold excepting instructions
        for (int k = 0; k < 3; k++) begin
            drive_in(1'b1, PC_W'(32'h0000_3020 + 4 * k), 1'b0);
            drive_inj(3'b001, EXC_ADES, '0, '0);
            step();
        end
        check("exc_fill_out", observed(), rec(1'b1, 1'b1, EXC_ADES, 32'h0000_3020, 1'b0));
        reset = 1'b1;
        en    = 3'b000;
        flush = 3'b000;
        drive_inj(3'b111, EXC_ADEL, EXC_RI, EXC_OV);
        step();
        reset = 1'b0;
        en    = 3'b111;
        drive_inj('0, '0, '0, '0);
        check("midreset_out", observed(), ZERO);
        drive_in(1'b1, 32'h0000_3030, 1'b0);
        step();
        drive_in(1'b0, '0, 1'b0);
        check("midreset_e1", observed(), ZERO);
        step();
        check("midreset_e2", observed(), ZERO);
        step();
        check("midreset_new", observed(), rec(1'b1, 1'b0, EXC_INT, 32'h0000_3030, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
